// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the intersection light bus: decodes both directions, checks
// sequencing and yellow dwell, and latches the first fault seen since reset or clear.
module traffic_light_monitor #(
   parameter int unsigned MIN_YELLOW = 100000000,
   parameter int unsigned CNT_W      = 28
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [5:0]  lights_in,
   input  logic        clear,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic        fault_pulse,
   output logic [15:0] ew_cycles
);

   typedef enum logic [1:0] {StRed, StYel, StGrn, StBad} light_e;

   localparam logic [CNT_W-1:0] MinYel   = CNT_W'(MIN_YELLOW);
   localparam logic [CNT_W-1:0] DwellMax = '1;

   function automatic light_e decode(input logic [2:0] t);
      case (t)
         3'b100:  return StRed;
         3'b010:  return StYel;
         3'b001:  return StGrn;
         default: return StBad;
      endcase
   endfunction

   // Only the three reverse steps are illegal; anything involving BAD is reported as code 1.
   function automatic logic illegal(input light_e p, input light_e c);
      return (p == StGrn && c == StRed) || (p == StYel && c == StGrn) ||
             (p == StRed && c == StYel);
   endfunction

   light_e           r_ew_prev, r_ns_prev;
   logic             r_valid;
   logic [CNT_W-1:0] r_ew_dwell, r_ns_dwell;
   logic             r_fault, r_pulse;
   logic [2:0]       r_code;
   logic [15:0]      r_ew_cycles;

   light_e     w_ew, w_ns;
   logic       w_short_ew, w_short_ns;
   logic [2:0] w_code;

   always_comb begin
      w_ew = decode(lights_in[5:3]);
      w_ns = decode(lights_in[2:0]);
      w_short_ew = (r_ew_prev == StYel) && (w_ew == StRed) && (r_ew_dwell < MinYel);
      w_short_ns = (r_ns_prev == StYel) && (w_ns == StRed) && (r_ns_dwell < MinYel);
      w_code = 3'd0;
      if (w_ew == StBad || w_ns == StBad) begin
         w_code = 3'd1;
      end else if (w_ew != StRed && w_ns != StRed) begin
         w_code = 3'd2;
      end else if (r_valid && (illegal(r_ew_prev, w_ew) || illegal(r_ns_prev, w_ns))) begin
         w_code = 3'd3;
      end else if (r_valid && (w_short_ew || w_short_ns)) begin
         w_code = 3'd4;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_valid     <= 1'b0;
         r_ew_prev   <= StBad;
         r_ns_prev   <= StBad;
         r_ew_dwell  <= '0;
         r_ns_dwell  <= '0;
         r_fault     <= 1'b0;
         r_code      <= 3'd0;
         r_pulse     <= 1'b0;
         r_ew_cycles <= 16'd0;
      end else begin
         r_valid   <= 1'b1;
         r_ew_prev <= w_ew;
         r_ns_prev <= w_ns;

         if (r_valid && w_ew == r_ew_prev) begin
            if (r_ew_dwell != DwellMax) r_ew_dwell <= r_ew_dwell + 1'b1;
         end else begin
            r_ew_dwell <= CNT_W'(1);
         end
         if (r_valid && w_ns == r_ns_prev) begin
            if (r_ns_dwell != DwellMax) r_ns_dwell <= r_ns_dwell + 1'b1;
         end else begin
            r_ns_dwell <= CNT_W'(1);
         end

         if (r_valid && r_ew_prev == StRed && w_ew == StGrn) begin
            r_ew_cycles <= r_ew_cycles + 16'd1;
         end

         r_pulse <= (w_code != 3'd0);
         // A violation coincident with clear wins and recaptures the code.
         if (w_code != 3'd0) begin
            r_fault <= 1'b1;
            if (!r_fault || clear) r_code <= w_code;
         end else if (clear) begin
            r_fault <= 1'b0;
            r_code  <= 3'd0;
         end
      end
   end

   assign fault       = r_fault;
   assign fault_code  = r_code;
   assign fault_pulse = r_pulse;
   assign ew_cycles   = r_ew_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Randomized and directed bench for traffic_light_monitor against a rule-level reference model.
module tb_traffic_light_monitor;

   localparam int unsigned MinY = 3;
   localparam int unsigned CntW = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [5:0]  lights_in = 6'b001_100;
   logic        clear = 1'b0;
   logic        fault;
   logic [2:0]  fault_code;
   logic        fault_pulse;
   logic [15:0] ew_cycles;

   int n_total = 0;
   int n_bad = 0;

   traffic_light_monitor #(.MIN_YELLOW(MinY), .CNT_W(CntW)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .lights_in  (lights_in),
      .clear      (clear),
      .fault      (fault),
      .fault_code (fault_code),
      .fault_pulse(fault_pulse),
      .ew_cycles  (ew_cycles)
   );

   always #5 clock = ~clock;

   // Model states: 0 red, 1 yellow, 2 green, 3 bad. Legal cycle is green -> yellow -> red -> green.
   int m_valid, m_ew_prev, m_ns_prev, m_ew_run, m_ns_run;
   int m_fault, m_code, m_pulse, m_cyc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
      end
   endtask

   function automatic int dec(input logic [2:0] t);
      if ($countones(t) != 1) return 3;
      if (t[2]) return 0;
      if (t[1]) return 1;
      return 2;
   endfunction

   function automatic bit bad_step(input int p, input int c);
      if (p == 3 || c == 3 || p == c) return 0;
      return c != (p + 2) % 3;
   endfunction

   task automatic model_step(input logic [5:0] l, input logic c, input logic rn);
      int e, n, code, max_run;
      if (!rn) begin
         m_valid = 0; m_ew_run = 0; m_ns_run = 0;
         m_fault = 0; m_code = 0; m_pulse = 0; m_cyc = 0;
         return;
      end
      max_run = (1 << CntW) - 1;
      e = dec(l[5:3]);
      n = dec(l[2:0]);
      code = 0;
      if (e == 3 || n == 3) code = 1;
      else if (e != 0 && n != 0) code = 2;
      else if (m_valid != 0 && (bad_step(m_ew_prev, e) || bad_step(m_ns_prev, n))) code = 3;
      else if (m_valid != 0 &&
               ((m_ew_prev == 1 && e == 0 && m_ew_run < MinY) ||
                (m_ns_prev == 1 && n == 0 && m_ns_run < MinY))) code = 4;
      if (m_valid != 0 && m_ew_prev == 0 && e == 2) m_cyc = (m_cyc + 1) % 65536;
      m_ew_run = (m_valid != 0 && e == m_ew_prev) ? ((m_ew_run < max_run) ? m_ew_run + 1 : max_run) : 1;
      m_ns_run = (m_valid != 0 && n == m_ns_prev) ? ((m_ns_run < max_run) ? m_ns_run + 1 : max_run) : 1;
      m_ew_prev = e;
      m_ns_prev = n;
      m_valid = 1;
      m_pulse = (code != 0);
      if (code != 0) begin
         if (m_fault == 0 || c) m_code = code;
         m_fault = 1;
      end else if (c) begin
         m_fault = 0;
         m_code = 0;
      end
   endtask

   task automatic step(input logic [5:0] l, input logic c = 1'b0, input logic rn = 1'b1);
      lights_in = l;
      clear = c;
      reset_n = rn;
      @(posedge clock);
      model_step(l, c, rn);
      #1;
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_code", 32'(fault_code), 32'(m_code));
      check("fault_pulse", 32'(fault_pulse), 32'(m_pulse));
      check("ew_cycles", 32'(ew_cycles), 32'(m_cyc));
   endtask

   task automatic hold(input logic [5:0] l, input int n);
      for (int i = 0; i < n; i++) step(l);
   endtask

   logic [5:0] pats [5] = '{6'b001_100, 6'b010_100, 6'b100_100, 6'b100_001, 6'b100_010};

   initial begin
      int pulses, idx, cnt;
      logic [5:0] pat;

      step(6'b001_100, 1'b0, 1'b0);
      step(6'b001_100, 1'b0, 1'b0);
      check("rst_fault", 32'(fault), 0);
      check("rst_cycles", 32'(ew_cycles), 0);

      // Legal cycle with yellows held exactly MIN_YELLOW.
      pulses = 0;
      for (int i = 0; i < 5; i++) begin step(6'b001_100); pulses += fault_pulse; end
      for (int i = 0; i < 3; i++) begin step(6'b010_100); pulses += fault_pulse; end
      step(6'b100_100); pulses += fault_pulse;
      step(6'b100_001); pulses += fault_pulse;
      check("legal_pulses", 32'(pulses), 0);
      check("legal_fault", 32'(fault), 0);
      check("legal_cycles0", 32'(ew_cycles), 0);
      hold(6'b100_010, 3);
      step(6'b100_100);
      step(6'b001_100);
      check("legal_cycles1", 32'(ew_cycles), 1);
      check("legal_fault2", 32'(fault), 0);

      // Conflict, then sticky code across a following illegal step.
      step(6'b001_001);
      check("conf_pulse", 32'(fault_pulse), 1);
      check("conf_code", 32'(fault_code), 2);
      step(6'b001_100);
      step(6'b001_100);
      check("conf_sticky", 32'(fault), 1);
      check("conf_code_kept", 32'(fault_code), 2);
      check("conf_pulse_low", 32'(fault_pulse), 0);

      step(6'b001_100, 1'b1);
      check("clear_fault", 32'(fault), 0);
      step(6'b100_100);
      check("illegal_code", 32'(fault_code), 3);

      // Short yellow vs exact-minimum yellow.
      step(6'b100_100, 1'b1);
      step(6'b001_100);
      hold(6'b010_100, 2);
      step(6'b100_100);
      check("short_yel_code", 32'(fault_code), 4);
      step(6'b100_100, 1'b1);
      step(6'b001_100);
      hold(6'b010_100, 3);
      step(6'b100_100);
      check("min_yel_fault", 32'(fault), 0);

      // Bad pattern, sticky code, clear, clear colliding with a violation.
      step(6'b001_100);
      step(6'b011_100);
      check("bad_code", 32'(fault_code), 1);
      step(6'b001_001);
      check("bad_code_kept", 32'(fault_code), 1);
      hold(6'b001_100, 2);
      step(6'b001_100, 1'b1);
      check("clr_fault", 32'(fault), 0);
      check("clr_code", 32'(fault_code), 0);
      step(6'b000_100, 1'b1);
      check("clr_vs_viol_fault", 32'(fault), 1);
      check("clr_vs_viol_code", 32'(fault_code), 1);

      // Reset mid-yellow discards history.
      step(6'b001_100, 1'b1);
      step(6'b010_100);
      step(6'b010_100, 1'b0, 1'b0);
      check("rst_mid_fault", 32'(fault), 0);
      check("rst_mid_code", 32'(fault_code), 0);
      step(6'b100_100, 1'b0, 1'b0);
      step(6'b100_100);
      check("post_rst_fault", 32'(fault), 0);
      check("post_rst_pulse", 32'(fault_pulse), 0);

      // Random walk mostly along the legal cycle, with glitches, clears and resets.
      idx = 0;
      for (int k = 0; k < 300; k++) begin
         cnt = $urandom_range(1, 5);
         if ($urandom_range(0, 9) < 8) begin
            idx = (idx + 1) % 5;
            pat = pats[idx];
         end else if ($urandom_range(0, 1) == 0) begin
            idx = $urandom_range(0, 4);
            pat = pats[idx];
         end else begin
            pat = 6'($urandom);
         end
         for (int j = 0; j < cnt; j++) begin
            step(pat, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0));
         end
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
